// File: rtl/adc_sample_buffer_pkg.sv
// Shared definitions for the ADC sample buffer: receiver state codes, sample width
// and a saturating-increment helper used by the statistics counters.
package adc_sample_buffer_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    ST_ESPERA = 3'b000,
    ST_FIN    = 3'b100,
    ST_SYNC   = 3'b110,
    ST_ERR    = 3'b111
  } rx_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_sample_buffer_if.sv
// Receiver-facing sample inputs plus the consumer valid/ready read port.
interface adc_sample_buffer_if;
  import adc_sample_buffer_pkg::*;

  logic [SAMPLE_W-1:0] rx_byte;
  logic [2:0]          rx_state;
  logic                rd_valid;
  logic                rd_ready;
  logic [SAMPLE_W-1:0] rd_data;

  modport slave  (input rx_byte, rx_state, rd_ready, output rd_valid, rd_data);
  modport master (output rx_byte, rx_state, rd_ready, input rd_valid, rd_data);

endinterface

// File: rtl/adc_sample_buffer_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers; reused by the
// channel-mux stages, so it knows nothing about samples or statistics.
module sync_fifo_fwft #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// Buffers completed ADC UART receptions into a FIFO for the consumer, counts frame
// errors and dropped samples, and flags link loss when samples stop arriving.
module adc_sample_buffer
  import adc_sample_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TMR_W          = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_sample_buffer_if.slave    bus,
  input  logic                  clr_stats,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            err_cnt,
  output logic [7:0]            ovf_cnt,
  output logic                  link_alive
);

  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_EXP = TMR_W'(TIMEOUT_CYCLES - 1);

  logic             done_q;
  logic             done_q2;
  logic             err_q;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             err_ev;
  logic             ovf_ev;
  logic [TMR_W-1:0] tmr;

  // The delay through done_q gives the receiver a cycle to settle rx_byte.
  assign push          = done_q & ~done_q2;
  assign err_ev        = (bus.rx_state == ST_ERR) & ~err_q;
  assign bus.rd_valid  = ~empty;
  assign pop           = bus.rd_valid & bus.rd_ready;
  assign ovf_ev        = push & full & ~pop;

  sync_fifo_fwft #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.rx_byte),
    .dout  (bus.rd_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= 1'b0;
      done_q2 <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= (bus.rx_state == ST_FIN);
      done_q2 <= done_q;
      err_q   <= (bus.rx_state == ST_ERR);
    end
  end

  // Clear beats a coincident event; that event is intentionally lost.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (err_ev) err_cnt <= sat_inc(err_cnt);
      if (ovf_ev) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr        <= '0;
      link_alive <= 1'b0;
    end else if (push) begin
      tmr        <= '0;
      link_alive <= 1'b1;
    end else begin
      if (tmr != TMR_MAX) tmr <= tmr + 1'b1;
      if (tmr == TMR_EXP) link_alive <= 1'b0;
    end
  end

endmodule
